fifo_sync_param: RTL and testbench
==================================

# fifo_sync_param

Parametrised synchronous FIFO, the next generation of the 8-bit/10-entry byte FIFO. It has configurable data width and depth (any depth ≥ 2, not only powers of two), a legal simultaneous push+pop, and an occupancy count. It also provides programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It sits between byte/word producers and consumers in the same clock domain, e.g. UART RX/TX buffering on the ECP5 designs.

## Interface
- WIDTH, 8, data word width in bits (≥ 1)
- DEPTH, 10, number of storage entries (≥ 2, need not be a power of two)
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush: empties FIFO, clears error flags
- push  in  1  write request
- data_in  in  WIDTH  write data
- pop  in  1  read request
- data_out  out  WIDTH  registered read data
- data_valid  out  1  one-cycle pulse: data_out updated by an accepted pop
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  sticky: push rejected because FIFO full
- underflow  out  1  sticky: pop rejected because FIFO empty

## Operation
- Storage: DEPTH × WIDTH array, write pointer wr_ptr and read pointer rd_ptr in 0..DEPTH-1. Pointers wrap explicitly DEPTH-1 → 0 by compare, with no modulo or power-of-two assumption.
- Full/empty are derived from count, not from pointer equality plus a last-op bit.
- Acceptance, evaluated on pre-edge state:
  - pop_ok = pop & !empty
  - push_ok = push & (!full | pop)
- Push and pop when full: both are accepted. The oldest word is read, the new word is written into the freed slot, and count is unchanged.
- Push and pop when empty: push is accepted, pop is rejected, underflow is set, and count becomes 1. There is no fall-through.
- Push and pop otherwise: both are accepted and count is unchanged.
- On push_ok: mem[wr_ptr] ← data_in, then wr_ptr advances.
- On pop_ok: data_out ← mem[rd_ptr], rd_ptr advances, and data_valid = 1 next cycle.
- Without pop_ok, data_out holds its last value and data_valid = 0.
- count update: count + push_ok − pop_ok.
- Sticky errors:
  - overflow is set by push & full & !pop.
  - underflow is set by pop & empty.
  - Both are cleared only by reset or clear.
- clear has priority over push/pop in the same cycle. It sets pointers = 0, count = 0, overflow = underflow = 0 and data_valid = 0, and leaves data_out unchanged. Memory contents are not cleared.
- Flags full, empty, almost_full and almost_empty are combinational decodes of the registered count, so they are glitch-free relative to clk.

## Timing
- Reset (reset_n = 0, asynchronous assert, released synchronously by the system):
  - wr_ptr = rd_ptr = 0, count = 0
  - data_out = 0, data_valid = 0
  - overflow = underflow = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0)
- Reset mid-operation discards all contents immediately, with no clock needed.
- Write latency: a word pushed at edge N can be popped at edge N+1 and appears on data_out after edge N+1.
- Read latency: 1 cycle. data_out and data_valid change at the same edge that consumes the pop.
- Flags and count reflect the edge's push/pop immediately after that edge.
- Throughput: one push and one pop per cycle, sustained, at any occupancy.

## Test plan
- Reset/idle: hold reset_n = 0 mid-run with count = 5 → count = 0, empty = 1, data_out = 0, data_valid = 0 asynchronously; pop afterwards → underflow = 1, count stays 0.
- Fill/drain with wrap (WIDTH = 8, DEPTH = 10):
  - Push 0x01..0x0A → full = 1, count = 10, almost_full from count 8.
  - An 11th push of 0xFF → rejected, overflow = 1.
  - Pop 10 → data_out = 0x01..0x0A in order, each with a data_valid pulse, empty = 1 at the end.
  - Repeat 3 times so the pointers wrap.
- Simultaneous full: FIFO full with 0x01..0x0A, push 0x55 + pop in one cycle → data_out = 0x01, count = 10, overflow = 0; later drain ends with 0x55.
- Simultaneous empty: push 0x33 + pop while empty → count = 1, underflow = 1, data_valid = 0; next pop → 0x33.
- Clear: count = 6 with overflow set, assert clear together with push → count = 0, empty = 1, overflow = 0, the push is ignored, data_out is unchanged.
- Non-default parameters (WIDTH = 16, DEPTH = 5, AF_LEVEL = 4, AE_LEVEL = 1): 1000 random push/pop cycles against a scoreboard queue → data, count and all flags match every cycle.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO: any depth >= 2, simultaneous push/pop,
// occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags. Registered read data with a one-cycle valid.
module fifo_sync_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 10,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_next;
   logic             push_ok;
   logic             pop_ok;

   // Pointers wrap by compare so non-power-of-two depths need no modulo.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Flags decode the registered count only, so they never glitch mid-cycle.
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   // A push into a full FIFO is legal when a pop frees the oldest slot.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop);

   // Occupancy after this edge's accepted operations.
   always_comb begin
      count_next = count;
      unique case ({push_ok, pop_ok})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Storage write; contents are never reset, a flush only moves pointers.
   always_ff @(posedge clk) begin
      if (push_ok && !clear) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers, count, read-valid pulse and sticky error flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         data_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         data_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (pop_ok) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         count      <= count_next;
         data_valid <= pop_ok;
         if (push && full && !pop) begin
            overflow <= 1'b1;
         end
         if (pop && empty) begin
            underflow <= 1'b1;
         end
      end
   end

   // Registered read data; holds its last value unless a pop is accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= '0;
      end else if (pop_ok && !clear) begin
         data_out <= mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a default 8x10 instance exercised with directed
// vectors and a 16x5 instance exercised with random traffic. Both are checked
// every cycle against queue-based models, plus literal expectations.
module tb_fifo_sync_param;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   // Instance A: defaults (WIDTH 8, DEPTH 10, AF 8, AE 2)
   logic       a_clear, a_push, a_pop;
   logic [7:0] a_din, a_dout;
   logic       a_dv, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
   logic [3:0] a_count;

   // Instance B: WIDTH 16, DEPTH 5, AF 4, AE 1
   logic        b_clear, b_push, b_pop;
   logic [15:0] b_din, b_dout;
   logic        b_dv, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
   logic [2:0]  b_count;

   fifo_sync_param dut_a (
      .clk(clk), .reset_n(reset_n), .clear(a_clear), .push(a_push),
      .data_in(a_din), .pop(a_pop), .data_out(a_dout), .data_valid(a_dv),
      .full(a_full), .empty(a_empty), .almost_full(a_af),
      .almost_empty(a_ae), .count(a_count), .overflow(a_ovf),
      .underflow(a_udf)
   );

   fifo_sync_param #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .clear(b_clear), .push(b_push),
      .data_in(b_din), .pop(b_pop), .data_out(b_dout), .data_valid(b_dv),
      .full(b_full), .empty(b_empty), .almost_full(b_af),
      .almost_empty(b_ae), .count(b_count), .overflow(b_ovf),
      .underflow(b_udf)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Model A: contents as a queue, outputs from the acceptance rules
   logic [7:0] qa[$];
   logic [7:0] ma_dout;
   bit         ma_dv, ma_ovf, ma_udf, ma_pok, ma_wok;
   int         ma_n;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         qa.delete();
         ma_dout = 8'h00; ma_dv = 0; ma_ovf = 0; ma_udf = 0;
      end else if (a_clear) begin
         qa.delete();
         ma_dv = 0; ma_ovf = 0; ma_udf = 0;
      end else begin
         ma_n   = qa.size();
         ma_pok = a_pop && (ma_n > 0);
         ma_wok = a_push && ((ma_n < 10) || a_pop);
         if (a_push && (ma_n == 10) && !a_pop) ma_ovf = 1;
         if (a_pop && (ma_n == 0)) ma_udf = 1;
         ma_dv = ma_pok;
         if (ma_pok) ma_dout = qa.pop_front();
         if (ma_wok) qa.push_back(a_din);
      end
   end

   // Model B: same rules for depth 5
   logic [15:0] qb[$];
   logic [15:0] mb_dout;
   bit          mb_dv, mb_ovf, mb_udf, mb_pok, mb_wok;
   int          mb_n;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         qb.delete();
         mb_dout = 16'h0000; mb_dv = 0; mb_ovf = 0; mb_udf = 0;
      end else if (b_clear) begin
         qb.delete();
         mb_dv = 0; mb_ovf = 0; mb_udf = 0;
      end else begin
         mb_n   = qb.size();
         mb_pok = b_pop && (mb_n > 0);
         mb_wok = b_push && ((mb_n < 5) || b_pop);
         if (b_push && (mb_n == 5) && !b_pop) mb_ovf = 1;
         if (b_pop && (mb_n == 0)) mb_udf = 1;
         mb_dv = mb_pok;
         if (mb_pok) mb_dout = qb.pop_front();
         if (mb_wok) qb.push_back(b_din);
      end
   end

   // Compare both instances against their models every falling edge
   always @(negedge clk) begin
      chk("a_count", 32'(a_count), 32'(qa.size()));
      chk("a_full",  32'(a_full),  32'(qa.size() == 10));
      chk("a_empty", 32'(a_empty), 32'(qa.size() == 0));
      chk("a_af",    32'(a_af),    32'(qa.size() >= 8));
      chk("a_ae",    32'(a_ae),    32'(qa.size() <= 2));
      chk("a_dout",  32'(a_dout),  32'(ma_dout));
      chk("a_dv",    32'(a_dv),    32'(ma_dv));
      chk("a_ovf",   32'(a_ovf),   32'(ma_ovf));
      chk("a_udf",   32'(a_udf),   32'(ma_udf));
      chk("b_count", 32'(b_count), 32'(qb.size()));
      chk("b_full",  32'(b_full),  32'(qb.size() == 5));
      chk("b_empty", 32'(b_empty), 32'(qb.size() == 0));
      chk("b_af",    32'(b_af),    32'(qb.size() >= 4));
      chk("b_ae",    32'(b_ae),    32'(qb.size() <= 1));
      chk("b_dout",  32'(b_dout),  32'(mb_dout));
      chk("b_dv",    32'(b_dv),    32'(mb_dv));
      chk("b_ovf",   32'(b_ovf),   32'(mb_ovf));
      chk("b_udf",   32'(b_udf),   32'(mb_udf));
   end

   // One cycle on instance A; returns 1 time unit after the edge
   task automatic step_a(input bit p, input logic [7:0] d, input bit po, input bit c);
      a_push = p; a_din = d; a_pop = po; a_clear = c;
      @(posedge clk);
      #1;
      a_push = 0; a_pop = 0; a_clear = 0; a_din = 8'h00;
   endtask

   // One cycle on instance B
   task automatic step_b(input bit p, input logic [15:0] d, input bit po);
      b_push = p; b_din = d; b_pop = po;
      @(posedge clk);
      #1;
      b_push = 0; b_pop = 0; b_din = 16'h0000;
   endtask

   initial begin
      a_clear = 0; a_push = 0; a_pop = 0; a_din = 8'h00;
      b_clear = 0; b_push = 0; b_pop = 0; b_din = 16'h0000;
      reset_n = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", 32'(a_count), 32'd0);
      chk("rst_empty", 32'(a_empty), 32'd1);
      chk("rst_full",  32'(a_full),  32'd0);
      chk("rst_ae",    32'(a_ae),    32'd1);
      chk("rst_af",    32'(a_af),    32'd0);
      chk("rst_dout",  32'(a_dout),  32'd0);
      chk("rst_dv",    32'(a_dv),    32'd0);
      reset_n = 1;

      // Asynchronous reset in the middle of operation
      for (int i = 0; i < 6; i++) step_a(1, 8'(8'h11 + i), 0, 0);
      step_a(0, 8'h00, 1, 0);
      chk("t1_count", 32'(a_count), 32'd5);
      chk("t1_dout",  32'(a_dout),  32'h11);
      chk("t1_dv",    32'(a_dv),    32'd1);
      #1 reset_n = 0;
      #1;
      chk("t1_async_count", 32'(a_count), 32'd0);
      chk("t1_async_empty", 32'(a_empty), 32'd1);
      chk("t1_async_dout",  32'(a_dout),  32'd0);
      chk("t1_async_dv",    32'(a_dv),    32'd0);
      @(posedge clk);
      #1 reset_n = 1;
      step_a(0, 8'h00, 1, 0);
      chk("t1_udf",   32'(a_udf),   32'd1);
      chk("t1_cnt0",  32'(a_count), 32'd0);
      chk("t1_dv0",   32'(a_dv),    32'd0);
      step_a(0, 8'h00, 0, 1);
      chk("t1_clr_udf", 32'(a_udf), 32'd0);

      // Fill/drain three times from an offset start so pointers wrap mid-array
      step_a(1, 8'hAA, 0, 0);
      step_a(0, 8'h00, 1, 0);
      chk("t2_pre_dout", 32'(a_dout), 32'hAA);
      for (int r = 0; r < 3; r++) begin
         for (int i = 1; i <= 10; i++) begin
            step_a(1, 8'(i), 0, 0);
            if (i == 7) chk("t2_af_7", 32'(a_af), 32'd0);
            if (i == 8) chk("t2_af_8", 32'(a_af), 32'd1);
         end
         chk("t2_full",  32'(a_full),  32'd1);
         chk("t2_count", 32'(a_count), 32'd10);
         if (r == 0) chk("t2_ovf0", 32'(a_ovf), 32'd0);
         step_a(1, 8'hFF, 0, 0);
         chk("t2_ovf",    32'(a_ovf),   32'd1);
         chk("t2_cnt_ov", 32'(a_count), 32'd10);
         for (int i = 1; i <= 10; i++) begin
            step_a(0, 8'h00, 1, 0);
            chk("t2_dout", 32'(a_dout), 32'(i));
            chk("t2_dv",   32'(a_dv),   32'd1);
         end
         chk("t2_empty", 32'(a_empty), 32'd1);
      end

      // Simultaneous push and pop while full
      step_a(0, 8'h00, 0, 1);
      for (int i = 1; i <= 10; i++) step_a(1, 8'(i), 0, 0);
      step_a(1, 8'h55, 1, 0);
      chk("t3_dout",  32'(a_dout),  32'h01);
      chk("t3_count", 32'(a_count), 32'd10);
      chk("t3_ovf",   32'(a_ovf),   32'd0);
      chk("t3_dv",    32'(a_dv),    32'd1);
      for (int i = 0; i < 10; i++) begin
         step_a(0, 8'h00, 1, 0);
         if (i == 0) chk("t3_first", 32'(a_dout), 32'h02);
         if (i == 9) chk("t3_last",  32'(a_dout), 32'h55);
      end
      chk("t3_empty", 32'(a_empty), 32'd1);

      // Simultaneous push and pop while empty: no fall-through
      step_a(1, 8'h33, 1, 0);
      chk("t4_count", 32'(a_count), 32'd1);
      chk("t4_udf",   32'(a_udf),   32'd1);
      chk("t4_dv",    32'(a_dv),    32'd0);
      step_a(0, 8'h00, 1, 0);
      chk("t4_dout",  32'(a_dout),  32'h33);
      chk("t4_dv1",   32'(a_dv),    32'd1);

      // Clear wins over a push in the same cycle
      step_a(0, 8'h00, 0, 1);
      for (int i = 0; i < 10; i++) step_a(1, 8'(8'hC0 + i), 0, 0);
      step_a(1, 8'hEE, 0, 0);
      for (int i = 0; i < 4; i++) step_a(0, 8'h00, 1, 0);
      chk("t5_count6", 32'(a_count), 32'd6);
      chk("t5_ovf1",   32'(a_ovf),   32'd1);
      step_a(1, 8'h77, 0, 1);
      chk("t5_count", 32'(a_count), 32'd0);
      chk("t5_empty", 32'(a_empty), 32'd1);
      chk("t5_ovf",   32'(a_ovf),   32'd0);
      chk("t5_dout",  32'(a_dout),  32'hC3);
      chk("t5_dv",    32'(a_dv),    32'd0);
      step_a(0, 8'h00, 1, 0);
      chk("t5_udf",   32'(a_udf),   32'd1);
      chk("t5_cnt",   32'(a_count), 32'd0);

      // Random traffic on the 16x5 instance with shifting push bias
      for (int k = 0; k < 1000; k++) begin
         int pprob;
         pprob = (((k / 100) % 2) == 0) ? 70 : 30;
         step_b($urandom_range(99) < pprob, 16'($urandom), $urandom_range(99) < 50);
      end
      step_b(0, 16'h0000, 0);
      step_b(0, 16'h0000, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
